// File: rtl/uart_pkg.sv
// Shared constants and types for the memory-mapped UART transmitter.
// Register offsets are relative to the peripheral's base address.
package uart_pkg;

  localparam logic [2:0] TXDATA_OFS = 3'h0;
  localparam logic [2:0] STATUS_OFS = 3'h4;

  localparam int unsigned StatusFullBit  = 0;
  localparam int unsigned StatusEmptyBit = 1;
  localparam int unsigned StatusBusyBit  = 2;
  localparam int unsigned StatusCountLsb = 8;

  typedef enum logic [1:0] {
    StIdle,
    StStart,
    StData,
    StStop
  } tx_state_e;

endpackage

// File: rtl/uart_tx.sv
// 8N1 serializer with a valid/ready byte input. Frames run back to back when a byte
// is offered during the last cycle of the stop bit.
module uart_tx
  import uart_pkg::*;
#(
  parameter int unsigned ClksPerBit = 104
) (
  input  logic       clk_i,
  input  logic       reset_i,
  input  logic       valid_i,
  input  logic [7:0] data_i,
  output logic       ready_o,
  output logic       tx_o,
  output logic       busy_o
);

  localparam int unsigned CntW = (ClksPerBit > 1) ? $clog2(ClksPerBit) : 1;
  localparam logic [CntW-1:0] CntMax = CntW'(ClksPerBit - 1);

  tx_state_e       state_q;
  logic [CntW-1:0] cnt_q;
  logic [2:0]      idx_q;
  logic [7:0]      shift_q;
  logic            tx_q;
  logic            bit_done;

  assign bit_done = (cnt_q == CntMax);
  // A byte is taken either from idle or in the final cycle of a stop bit.
  assign ready_o  = (state_q == StIdle) || ((state_q == StStop) && bit_done);
  assign busy_o   = (state_q != StIdle);
  assign tx_o     = tx_q;

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      idx_q   <= '0;
      shift_q <= '0;
      tx_q    <= 1'b1;
    end else begin
      if (state_q == StIdle || bit_done) begin
        cnt_q <= '0;
      end else begin
        cnt_q <= cnt_q + 1'b1;
      end

      unique case (state_q)
        StIdle: begin
          tx_q <= 1'b1;
          if (valid_i) begin
            shift_q <= data_i;
            tx_q    <= 1'b0;
            state_q <= StStart;
          end
        end
        StStart: begin
          if (bit_done) begin
            tx_q    <= shift_q[0];
            shift_q <= shift_q >> 1;
            idx_q   <= '0;
            state_q <= StData;
          end
        end
        StData: begin
          if (bit_done) begin
            if (idx_q == 3'd7) begin
              tx_q    <= 1'b1;
              state_q <= StStop;
            end else begin
              tx_q    <= shift_q[0];
              shift_q <= shift_q >> 1;
              idx_q   <= idx_q + 3'd1;
            end
          end
        end
        StStop: begin
          if (bit_done) begin
            if (valid_i) begin
              shift_q <= data_i;
              tx_q    <= 1'b0;
              state_q <= StStart;
            end else begin
              state_q <= StIdle;
            end
          end
        end
        default: begin
          tx_q    <= 1'b1;
          state_q <= StIdle;
        end
      endcase
    end
  end

endmodule

// File: rtl/uart_tx_mmio.sv
// picorv32 native-bus UART transmitter: TXDATA push register, STATUS poll register,
// a circular TX FIFO and the 8N1 serializer.
module uart_tx_mmio
  import uart_pkg::*;
#(
  parameter int unsigned ClkFreq   = 12000000,
  parameter int unsigned BaudRate  = 115200,
  parameter logic [31:0] BaseAddr  = 32'h0000_1000,
  parameter int unsigned FifoDepth = 16
) (
  input  logic        clk_i,
  input  logic        reset_i,
  input  logic        mem_valid_i,
  input  logic [31:0] mem_addr_i,
  input  logic [31:0] mem_wdata_i,
  input  logic [3:0]  mem_wstrb_i,
  output logic        sel_o,
  output logic [31:0] mem_rdata_o,
  output logic        mem_ready_o,
  output logic        tx_o
);

  localparam int unsigned AW         = $clog2(FifoDepth);
  localparam int unsigned ClksPerBit = ClkFreq / BaudRate;

  logic [AW:0]   wptr_q, rptr_q;
  logic [7:0]    fifo_q [FifoDepth];
  logic          mem_ready_q;
  logic [31:0]   mem_rdata_q, mem_rdata_d;

  logic [31:0]   offset;
  logic [2:0]    reg_ofs;
  logic          is_write, is_status, push_req;
  logic          fifo_full, fifo_empty;
  logic [AW:0]   fifo_count;
  logic          tx_ready, tx_busy;
  logic          req, accept, push, pop;
  logic [31:0]   status;
  logic          unused;

  // Unsigned subtraction makes any address below BaseAddr wrap far out of range.
  assign offset    = mem_addr_i - BaseAddr;
  assign sel_o     = (offset < 32'd8);
  assign reg_ofs   = {offset[2], 2'b00};
  assign is_write  = |mem_wstrb_i;
  assign is_status = (reg_ofs == STATUS_OFS);
  assign push_req  = is_write && (reg_ofs == TXDATA_OFS) && mem_wstrb_i[0];
  assign unused    = ^{offset[31:3], offset[1:0], mem_wdata_i[31:8], mem_wstrb_i[3:1]};

  assign fifo_empty = (wptr_q == rptr_q);
  assign fifo_full  = (wptr_q[AW] != rptr_q[AW]) && (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
  assign fifo_count = wptr_q - rptr_q;

  assign pop    = tx_ready && !fifo_empty;
  assign req    = mem_valid_i && sel_o && !mem_ready_q;
  // A full FIFO stalls the push unless the serializer frees a slot this very cycle.
  assign accept = req && !(push_req && fifo_full && !pop);
  assign push   = accept && push_req;

  always_comb begin
    status                               = '0;
    status[StatusFullBit]                = fifo_full;
    status[StatusEmptyBit]               = fifo_empty;
    status[StatusBusyBit]                = tx_busy;
    status[StatusCountLsb +: 8]          = 8'(fifo_count);
  end

  always_comb begin
    mem_rdata_d = '0;
    if (accept && !is_write && is_status) begin
      mem_rdata_d = status;
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      wptr_q      <= '0;
      rptr_q      <= '0;
      mem_ready_q <= 1'b0;
      mem_rdata_q <= '0;
    end else begin
      mem_ready_q <= accept;
      mem_rdata_q <= mem_rdata_d;
      if (push) begin
        wptr_q <= wptr_q + 1'b1;
      end
      if (pop) begin
        rptr_q <= rptr_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (push) begin
      fifo_q[wptr_q[AW-1:0]] <= mem_wdata_i[7:0];
    end
  end

  assign mem_ready_o = mem_ready_q;
  assign mem_rdata_o = mem_rdata_q;

  uart_tx #(
    .ClksPerBit(ClksPerBit)
  ) u_uart_tx (
    .clk_i  (clk_i),
    .reset_i(reset_i),
    .valid_i(!fifo_empty),
    .data_i (fifo_q[rptr_q[AW-1:0]]),
    .ready_o(tx_ready),
    .tx_o   (tx_o),
    .busy_o (tx_busy)
  );

endmodule

// File: tb/tb_uart_tx_mmio.sv
// Self-checking bench for uart_tx_mmio: bus tasks per scenario plus a serial monitor
// that checks every decoded frame against a queue of expected bytes.
module tb_uart_tx_mmio;

  localparam int unsigned Cpb      = 12000000 / 115200;
  localparam logic [31:0] Base     = 32'h0000_1000;
  localparam logic [31:0] TxAddr   = Base;
  localparam logic [31:0] StAddr   = Base + 32'd4;

  logic        clk = 1'b0;
  logic        reset_i = 1'b1;
  logic        mem_valid = 1'b0;
  logic [31:0] mem_addr = '0;
  logic [31:0] mem_wdata = '0;
  logic [3:0]  mem_wstrb = '0;
  logic        sel_o, mem_ready_o, tx_o;
  logic [31:0] mem_rdata_o;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  logic [7:0] exp_q[$];
  int         start_q[$];
  int         frames_done = 0;

  logic       mon_active = 1'b0;
  int         mon_bit, mon_cnt, mon_bad;
  logic [7:0] mon_exp;

  uart_tx_mmio dut (
    .clk_i      (clk),
    .reset_i    (reset_i),
    .mem_valid_i(mem_valid),
    .mem_addr_i (mem_addr),
    .mem_wdata_i(mem_wdata),
    .mem_wstrb_i(mem_wstrb),
    .sel_o      (sel_o),
    .mem_rdata_o(mem_rdata_o),
    .mem_ready_o(mem_ready_o),
    .tx_o       (tx_o)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  // Serial monitor: samples every cycle, each bit must hold for exactly Cpb cycles.
  always @(negedge clk) begin
    logic expv;
    if (reset_i) begin
      mon_active = 1'b0;
    end else if (!mon_active) begin
      if (tx_o === 1'b0) begin
        mon_active = 1'b1;
        mon_bit = 0;
        mon_cnt = 1;
        mon_bad = 0;
        start_q.push_back(cyc);
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_frame: start bit at cycle %0d, required no frame", cyc);
          mon_exp = 8'h00;
        end else begin
          mon_exp = exp_q.pop_front();
        end
      end
    end else begin
      if (mon_bit == 0) expv = 1'b0;
      else if (mon_bit == 9) expv = 1'b1;
      else expv = mon_exp[mon_bit-1];
      if (tx_o !== expv) mon_bad++;
      mon_cnt++;
      if (mon_cnt == Cpb) begin
        mon_cnt = 0;
        mon_bit++;
        if (mon_bit == 10) begin
          mon_active = 1'b0;
          frames_done++;
          checks++;
          if (mon_bad != 0) begin
            errors++;
            $display("FAIL frame_bits: byte %02h had %0d wrong samples, required 0",
                     mon_exp, mon_bad);
          end
        end
      end
    end
  end

  task automatic bus_access(input logic [31:0] addr, input logic [31:0] wdata,
                            input logic [3:0] strb, input int bound,
                            output logic [31:0] rdata, output int lat, output int rdy_cyc);
    logic got = 1'b0;
    @(posedge clk); #1;
    mem_valid = 1'b1;
    mem_addr  = addr;
    mem_wdata = wdata;
    mem_wstrb = strb;
    lat = 0;
    rdata = '0;
    rdy_cyc = -1;
    for (int i = 0; i < bound; i++) begin
      @(negedge clk);
      if (mem_ready_o === 1'b1) begin
        got = 1'b1;
        rdata = mem_rdata_o;
        rdy_cyc = cyc;
        break;
      end
      lat++;
    end
    if (!got) lat = -1;
    @(posedge clk); #1;
    mem_valid = 1'b0;
    mem_wstrb = '0;
  endtask

  task automatic wait_idle(input int bound, output logic ok);
    ok = 1'b0;
    for (int i = 0; i < bound; i++) begin
      @(negedge clk);
      if (exp_q.size() == 0 && !mon_active) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic test_reset();
    logic [31:0] rd;
    int lat, rc, bad;
    reset_i = 1'b1;
    repeat (3) @(posedge clk);
    #1 reset_i = 1'b0;
    @(negedge clk);
    checks++;
    if (tx_o !== 1'b1 || mem_ready_o !== 1'b0 || mem_rdata_o !== 32'h0) begin
      errors++;
      $display("FAIL reset_outputs: tx=%b ready=%b rdata=%h, required 1 0 0",
               tx_o, mem_ready_o, mem_rdata_o);
    end
    bus_access(StAddr, 32'h0, 4'b0000, 10, rd, lat, rc);
    checks++;
    if (lat !== 1) begin
      errors++;
      $display("FAIL reset_status_latency: got %0d, required 1", lat);
    end
    checks++;
    if (rd !== 32'h0000_0002) begin
      errors++;
      $display("FAIL reset_status: got %h, required 00000002", rd);
    end
    bad = 0;
    repeat (50) begin
      @(negedge clk);
      if (tx_o !== 1'b1) bad++;
    end
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL reset_tx_idle: %0d low samples, required 0", bad);
    end
  endtask

  task automatic test_single();
    logic [31:0] rd;
    int lat, rc, lat2, rc2;
    logic ok;
    start_q.delete();
    exp_q.push_back(8'h55);
    bus_access(TxAddr, 32'hFFFF_FF55, 4'b0001, 10, rd, lat, rc);
    checks++;
    if (lat !== 1) begin
      errors++;
      $display("FAIL single_write_latency: got %0d, required 1", lat);
    end
    bus_access(StAddr, 32'h0, 4'b0000, 10, rd, lat2, rc2);
    checks++;
    if (rd !== 32'h0000_0006) begin
      errors++;
      $display("FAIL single_status_busy: got %h, required 00000006", rd);
    end
    wait_idle(1200, ok);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL single_frame_timeout: frame incomplete, required done within 1200 cycles");
    end
    checks++;
    if (start_q.size() < 1 || start_q[0] != rc + 1) begin
      errors++;
      $display("FAIL single_start_cycle: got %0d, required %0d",
               (start_q.size() > 0) ? start_q[0] : -1, rc + 1);
    end
    repeat (2) @(posedge clk);
    bus_access(StAddr, 32'h0, 4'b0000, 10, rd, lat2, rc2);
    checks++;
    if (rd !== 32'h0000_0002) begin
      errors++;
      $display("FAIL single_status_after: got %h, required 00000002", rd);
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] rd;
    int lat, rc;
    logic ok;
    start_q.delete();
    exp_q.push_back(8'hA5);
    bus_access(TxAddr, 32'h0000_00A5, 4'b1111, 10, rd, lat, rc);
    exp_q.push_back(8'h3C);
    bus_access(TxAddr, 32'h0000_003C, 4'b0001, 10, rd, lat, rc);
    wait_idle(2500, ok);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL b2b_timeout: frames incomplete, required done within 2500 cycles");
    end
    checks++;
    if (start_q.size() != 2 || start_q[1] - start_q[0] != 10 * Cpb) begin
      errors++;
      $display("FAIL b2b_gap: %0d starts, spacing %0d, required 2 starts spacing %0d",
               start_q.size(), (start_q.size() == 2) ? start_q[1] - start_q[0] : -1,
               10 * Cpb);
    end
  endtask

  task automatic test_fifo_full();
    logic [31:0] rd;
    int lat, rc0, rc;
    logic ok;
    exp_q.push_back(8'hC0);
    bus_access(TxAddr, 32'h0000_00C0, 4'b0001, 10, rd, lat, rc0);
    for (int i = 1; i <= 16; i++) begin
      exp_q.push_back(8'(i * 7));
      bus_access(TxAddr, 32'(i * 7), 4'b0001, 10, rd, lat, rc);
    end
    bus_access(StAddr, 32'h0, 4'b0000, 10, rd, lat, rc);
    checks++;
    if (rd !== 32'h0000_1005) begin
      errors++;
      $display("FAIL full_status: got %h, required 00001005", rd);
    end
    exp_q.push_back(8'hEE);
    bus_access(TxAddr, 32'h0000_00EE, 4'b0001, 2000, rd, lat, rc);
    checks++;
    if (rc != rc0 + 10 * Cpb + 1) begin
      errors++;
      $display("FAIL full_stall_release: ready at cycle %0d, required %0d",
               rc, rc0 + 10 * Cpb + 1);
    end
    checks++;
    if (tx_o !== 1'b0) begin
      errors++;
      $display("FAIL full_release_tx: tx=%b at release, required 0 (next start bit)", tx_o);
    end
    wait_idle(20000, ok);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL full_drain_timeout: queue not drained, required within 20000 cycles");
    end
    bus_access(StAddr, 32'h0, 4'b0000, 10, rd, lat, rc);
    checks++;
    if (rd !== 32'h0000_0002) begin
      errors++;
      $display("FAIL full_status_after: got %h, required 00000002", rd);
    end
  endtask

  task automatic test_strobe_window();
    logic [31:0] rd;
    int lat, rc, bad, fd;
    logic [31:0] addrs [3];
    logic [3:0]  strbs [3];
    fd = frames_done;
    bus_access(TxAddr, 32'h0000_00AB, 4'b0010, 10, rd, lat, rc);
    checks++;
    if (lat !== 1) begin
      errors++;
      $display("FAIL strobe_latency: got %0d, required 1", lat);
    end
    bus_access(TxAddr, 32'h0, 4'b0000, 10, rd, lat, rc);
    checks++;
    if (lat !== 1 || rd !== 32'h0) begin
      errors++;
      $display("FAIL txdata_read: lat %0d data %h, required 1 00000000", lat, rd);
    end
    bus_access(StAddr, 32'h0, 4'b0000, 10, rd, lat, rc);
    checks++;
    if (rd !== 32'h0000_0002) begin
      errors++;
      $display("FAIL strobe_status: got %h, required 00000002", rd);
    end
    addrs[0] = Base + 32'd8;  strbs[0] = 4'b0000;
    addrs[1] = Base + 32'd8;  strbs[1] = 4'b0001;
    addrs[2] = Base - 32'd4;  strbs[2] = 4'b0001;
    for (int k = 0; k < 3; k++) begin
      bad = 0;
      @(posedge clk); #1;
      mem_valid = 1'b1;
      mem_addr  = addrs[k];
      mem_wdata = 32'h0000_0099;
      mem_wstrb = strbs[k];
      repeat (8) begin
        @(negedge clk);
        if (sel_o !== 1'b0 || mem_ready_o !== 1'b0) bad++;
      end
      @(posedge clk); #1;
      mem_valid = 1'b0;
      mem_wstrb = '0;
      checks++;
      if (bad != 0) begin
        errors++;
        $display("FAIL out_of_window_%0d: addr %h had %0d bad samples, required 0",
                 k, addrs[k], bad);
      end
    end
    bad = 0;
    repeat (200) begin
      @(negedge clk);
      if (tx_o !== 1'b1) bad++;
    end
    checks++;
    if (bad != 0 || frames_done != fd) begin
      errors++;
      $display("FAIL strobe_no_tx: %0d low samples, %0d frames, required 0 0",
               bad, frames_done - fd);
    end
    bus_access(StAddr, 32'h0, 4'b0000, 10, rd, lat, rc);
    checks++;
    if (rd !== 32'h0000_0002) begin
      errors++;
      $display("FAIL window_status: got %h, required 00000002", rd);
    end
  endtask

  task automatic test_reset_mid();
    logic [31:0] rd;
    int lat, rc, bad, fd;
    logic got;
    exp_q.push_back(8'h12);
    bus_access(TxAddr, 32'h12, 4'b0001, 10, rd, lat, rc);
    exp_q.push_back(8'h34);
    bus_access(TxAddr, 32'h34, 4'b0001, 10, rd, lat, rc);
    exp_q.push_back(8'h56);
    bus_access(TxAddr, 32'h56, 4'b0001, 10, rd, lat, rc);
    exp_q.push_back(8'h78);
    bus_access(TxAddr, 32'h78, 4'b0001, 10, rd, lat, rc);
    got = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (mon_active) begin
        got = 1'b1;
        break;
      end
    end
    checks++;
    if (!got) begin
      errors++;
      $display("FAIL mid_start_timeout: no start bit, required within 100 cycles");
    end
    repeat (3 * Cpb) @(posedge clk);
    #1 reset_i = 1'b1;
    @(posedge clk);
    #1 reset_i = 1'b0;
    exp_q.delete();
    fd = frames_done;
    @(negedge clk);
    checks++;
    if (tx_o !== 1'b1) begin
      errors++;
      $display("FAIL mid_reset_tx: got %b, required 1", tx_o);
    end
    bus_access(StAddr, 32'h0, 4'b0000, 10, rd, lat, rc);
    checks++;
    if (rd !== 32'h0000_0002) begin
      errors++;
      $display("FAIL mid_reset_status: got %h, required 00000002", rd);
    end
    bad = 0;
    repeat (2500) begin
      @(negedge clk);
      if (tx_o !== 1'b1) bad++;
    end
    checks++;
    if (bad != 0 || frames_done != fd) begin
      errors++;
      $display("FAIL mid_reset_quiet: %0d low samples, %0d frames, required 0 0",
               bad, frames_done - fd);
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_fifo_full();
    test_strobe_window();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

endmodule
